// File: rtl/fp16_mul_sched_if.sv
// Request, multiplier and result signals of the FP16 multiplier scheduler.
// The scheduler takes the slave view; requesters and the multiplier take the master view.
interface fp16_mul_sched_if #(
    parameter int N_REQ = 4
);
    logic                 sched_en;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_ready;
    logic [16*N_REQ-1:0]  req_a;
    logic [16*N_REQ-1:0]  req_b;
    logic [15:0]          mul_data1;
    logic [15:0]          mul_data2;
    logic                 mul_valid;
    logic [15:0]          mul_result;
    logic                 mul_update;
    logic [N_REQ-1:0]     res_valid;
    logic [15:0]          res_data;
    logic                 busy;
    logic                 err;

    modport master (
        output sched_en, req_valid, req_a, req_b, mul_result, mul_update,
        input  req_ready, mul_data1, mul_data2, mul_valid, res_valid, res_data, busy, err
    );

    modport slave (
        input  sched_en, req_valid, req_a, req_b, mul_result, mul_update,
        output req_ready, mul_data1, mul_data2, mul_valid, res_valid, res_data, busy, err
    );
endinterface

// File: rtl/fp16_mul_sched.sv
// Round-robin scheduler sharing one fixed-latency FP16 multiplier among N_REQ requesters;
// a {valid, index} tag pipeline routes each multiplier result back to its requester.
module fp16_mul_sched #(
    parameter int N_REQ   = 4,
    parameter int MUL_LAT = 5
) (
    input logic              clk,
    input logic              rst_n,
    fp16_mul_sched_if.slave  bus
);
    localparam int IW = $clog2(N_REQ);

    logic [IW-1:0]    ptr;
    logic [IW-1:0]    grant_idx;
    logic [N_REQ-1:0] grant;
    logic             found;
    logic             accept;
    int               j;

    logic [MUL_LAT:0] tag_v;
    logic [IW-1:0]    tag_idx [MUL_LAT+1];
    logic             tag_out_v;

    logic [15:0]      mul_data1_q, mul_data2_q, res_data_q;
    logic             mul_valid_q, err_q;
    logic [N_REQ-1:0] res_valid_q;

    // NOTE: every variable gets a default before the search loop so no latch is inferred.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        j         = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!found && bus.req_valid[j]) begin
                found     = 1'b1;
                grant_idx = IW'(j);
            end
        end
        if (bus.sched_en && found) grant[grant_idx] = 1'b1;
    end

    assign accept    = |grant;
    assign tag_out_v = tag_v[MUL_LAT];

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr         <= '0;
            tag_v       <= '0;
            mul_valid_q <= 1'b0;
            mul_data1_q <= '0;
            mul_data2_q <= '0;
            res_valid_q <= '0;
            res_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            tag_v       <= {tag_v[MUL_LAT-1:0], accept};
            mul_valid_q <= accept;
            if (accept) begin
                ptr         <= (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
                mul_data1_q <= bus.req_a[16*grant_idx +: 16];
                mul_data2_q <= bus.req_b[16*grant_idx +: 16];
            end
            res_valid_q <= '0;
            if (bus.mul_update && tag_out_v) begin
                res_valid_q[tag_idx[MUL_LAT]] <= 1'b1;
                res_data_q                    <= bus.mul_result;
            end
            if (bus.mul_update != tag_out_v) err_q <= 1'b1;
        end
    end

    // NOTE: the index stages are left unreset; they are only ever read when the matching tag_v bit is set.
    always_ff @(posedge clk) begin
        tag_idx[0] <= grant_idx;
        for (int s = 1; s <= MUL_LAT; s++) tag_idx[s] <= tag_idx[s-1];
    end

    assign bus.req_ready = grant;
    assign bus.mul_data1 = mul_data1_q;
    assign bus.mul_data2 = mul_data2_q;
    assign bus.mul_valid = mul_valid_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.busy      = (|tag_v) | (|res_valid_q);
    assign bus.err       = err_q;
endmodule

// File: tb/tb_fp16_mul_sched.sv
// Directed bench for fp16_mul_sched with a fixed-latency FP16 multiplier stub
// sharing the scheduler's reset.
module tb_fp16_mul_sched;
    localparam int N_REQ   = 4;
    localparam int MUL_LAT = 5;

    logic clk;
    logic rst_n;
    logic inject;
    int   n_checks;
    int   n_pass;

    fp16_mul_sched_if #(.N_REQ(N_REQ)) bus ();

    fp16_mul_sched #(.N_REQ(N_REQ), .MUL_LAT(MUL_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Normal-operand FP16 multiply, truncating; adequate for the exact products used here.
    function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
        logic [21:0] p;
        logic [9:0]  m;
        int          e;
        p = {1'b1, a[9:0]} * {1'b1, b[9:0]};
        e = int'(a[14:10]) + int'(b[14:10]) - 15;
        if (p[21]) begin
            m = p[20:11];
            e = e + 1;
        end else begin
            m = p[19:10];
        end
        return {a[15] ^ b[15], e[4:0], m};
    endfunction

    logic [MUL_LAT-1:0] stub_v;
    logic [15:0]        stub_d [MUL_LAT];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_v <= '0;
        end else begin
            stub_v    <= {stub_v[MUL_LAT-2:0], bus.mul_valid};
            stub_d[0] <= fp16_mul(bus.mul_data1, bus.mul_data2);
            for (int k = 1; k < MUL_LAT; k++) stub_d[k] <= stub_d[k-1];
        end
    end

    assign bus.mul_update = stub_v[MUL_LAT-1] | inject;
    assign bus.mul_result = stub_d[MUL_LAT-1];

    // Hand-computed products: 1.0*2.0, 2.0*3.0, 0.5*8.0, -2.0*5.0.
    logic [15:0] exp_prod [N_REQ];
    initial exp_prod = '{16'h4000, 16'h4600, 16'h4400, 16'hC900};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] prod_of(input logic [3:0] onehot);
        logic [15:0] r;
        r = 16'h0;
        for (int i = 0; i < N_REQ; i++) if (onehot[i]) r = exp_prod[i];
        return r;
    endfunction

    // One cycle: drive requests, then check the grant and the registered result state.
    task automatic cycle_check(input logic [3:0] rv, input logic en, input logic [3:0] exp_ready,
                               input logic [3:0] exp_res, input logic exp_busy);
        bus.req_valid = rv;
        bus.sched_en  = en;
        #1;
        check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        check("res_valid", 32'(bus.res_valid), 32'(exp_res));
        check("busy", 32'(bus.busy), 32'(exp_busy));
        if (exp_res != 4'b0) check("res_data", 32'(bus.res_data), 32'(prod_of(exp_res)));
        tick();
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        inject        = 1'b0;
        bus.req_valid = '0;
        bus.sched_en  = 1'b0;
        #1;
        check("rst mul_valid", 32'(bus.mul_valid), 32'd0);
        check("rst mul_data1", 32'(bus.mul_data1), 32'd0);
        check("rst mul_data2", 32'(bus.mul_data2), 32'd0);
        check("rst res_valid", 32'(bus.res_valid), 32'd0);
        check("rst res_data", 32'(bus.res_data), 32'd0);
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst err", 32'(bus.err), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        rst_n         = 1'b0;
        inject        = 1'b0;
        bus.sched_en  = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = {16'hC000, 16'h3800, 16'h4000, 16'h3C00};
        bus.req_b     = {16'h4500, 16'h4800, 16'h4200, 16'h4000};
        tick();

        // Single operation from requester 0.
        do_reset();
        cycle_check(4'b0001, 1'b1, 4'b0001, 4'b0000, 1'b0);
        check("mul_valid t+1", 32'(bus.mul_valid), 32'd1);
        check("mul_data1 t+1", 32'(bus.mul_data1), 32'h3C00);
        check("mul_data2 t+1", 32'(bus.mul_data2), 32'h4000);
        for (int c = 1; c < 7; c++) cycle_check(4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1);
        cycle_check(4'b0000, 1'b1, 4'b0000, 4'b0001, 1'b1);
        check("mul_valid idle", 32'(bus.mul_valid), 32'd0);
        check("res_data held", 32'(bus.res_data), 32'h4000);
        cycle_check(4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0);

        // All four requesting for 8 cycles: grants and results rotate 0,1,2,3.
        do_reset();
        for (int c = 0; c < 16; c++)
            cycle_check((c < 8) ? 4'b1111 : 4'b0000, 1'b1,
                        (c < 8) ? 4'(1 << (c % 4)) : 4'b0000,
                        (c >= 7 && c <= 14) ? 4'(1 << ((c - 7) % 4)) : 4'b0000,
                        (c >= 1 && c <= 14));

        // Move ptr to 2, then req_valid=1011 grants 3, 0, 1; requester 2 never sees ready.
        do_reset();
        cycle_check(4'b0010, 1'b1, 4'b0010, 4'b0000, 1'b0);
        cycle_check(4'b1011, 1'b1, 4'b1000, 4'b0000, 1'b1);
        cycle_check(4'b1011, 1'b1, 4'b0001, 4'b0000, 1'b1);
        cycle_check(4'b1011, 1'b1, 4'b0010, 4'b0000, 1'b1);
        for (int c = 4; c < 7; c++) cycle_check(4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1);
        cycle_check(4'b0000, 1'b1, 4'b0000, 4'b0010, 1'b1);
        cycle_check(4'b0000, 1'b1, 4'b0000, 4'b1000, 1'b1);
        cycle_check(4'b0000, 1'b1, 4'b0000, 4'b0001, 1'b1);
        cycle_check(4'b0000, 1'b1, 4'b0000, 4'b0010, 1'b1);
        cycle_check(4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0);

        // Three accepts, then sched_en drops with requests still pending; in-flight ops drain.
        do_reset();
        for (int c = 0; c < 12; c++)
            cycle_check(4'b1111, (c < 3),
                        (c < 3) ? 4'(1 << c) : 4'b0000,
                        (c >= 7 && c <= 9) ? 4'(1 << (c - 7)) : 4'b0000,
                        (c >= 1 && c <= 9));

        // Spurious multiplier update sets a sticky error and produces no result.
        do_reset();
        bus.sched_en = 1'b1;
        inject       = 1'b1;
        #1;
        check("err before", 32'(bus.err), 32'd0);
        tick();
        inject = 1'b0;
        check("err set", 32'(bus.err), 32'd1);
        check("spurious res_valid", 32'(bus.res_valid), 32'd0);
        for (int c = 0; c < 4; c++) cycle_check(4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0);
        check("err sticky", 32'(bus.err), 32'd1);

        // Reset three cycles after an accept flushes scheduler and multiplier alike.
        do_reset();
        cycle_check(4'b0001, 1'b1, 4'b0001, 4'b0000, 1'b0);
        cycle_check(4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1);
        cycle_check(4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1);
        check("pre-flush mul_data1", 32'(bus.mul_data1), 32'h3C00);
        do_reset();
        bus.sched_en = 1'b1;
        for (int c = 0; c < 10; c++) cycle_check(4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0);
        check("post-flush err", 32'(bus.err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
